// File: rtl/modem_pkg.sv
// Shared modem constants and helpers: LUT geometry defaults, index width
// derivation, quarter-period offset and the requester-id type.
package modem_pkg;

  localparam int CARRIER_SAMPLES_PER_PERIOD = 512;
  localparam int FIXDT_24_WIDTH             = 24;
  localparam int NUM_REQ_DEFAULT            = 4;

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;

  function automatic int idx_width(input int samples);
    return $clog2(samples);
  endfunction

  // sin(x) = cos(x - T/4), so a sine lookup is a cosine lookup a quarter period back
  function automatic int quarter_offset(input int samples);
    return samples / 4;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last
// winner; the pointer moves to the winner whenever advance is high.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_id  = ptr;
    grant_any = 1'b0;
    cand      = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        grant_any   = 1'b1;
      end
    end
    // Nothing may be accepted while reset is held, even with requests pending
    if (rst) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (advance && grant_any) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/cosine_lut_arbiter.sv
// Shares one cosine_lut read port among NUM_REQ phase consumers: round-robin
// grant, sine via quarter-period index offset, fixed-latency response routing.
module cosine_lut_arbiter
  import modem_pkg::*;
#(
  parameter int  NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int  SAMPLES     = CARRIER_SAMPLES_PER_PERIOD,
  parameter int  DATA_W      = FIXDT_24_WIDTH,
  parameter int  LUT_LATENCY = 1,
  localparam int IDX_W       = idx_width(SAMPLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_sin,
  input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [IDX_W-1:0]          lut_idx,
  input  logic [DATA_W-1:0]         lut_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PIPE_D = 1 + LUT_LATENCY;
  localparam logic [IDX_W-1:0] QUARTER = IDX_W'(quarter_offset(SAMPLES));

  logic [NUM_REQ-1:0]            grant;
  logic [ID_W-1:0]               grant_id;
  logic                          grant_any;
  logic [IDX_W-1:0]              sel_idx;
  logic [IDX_W-1:0]              next_idx;
  logic [PIPE_D-1:0]             tag_v;
  logic [PIPE_D-1:0][ID_W-1:0]   tag_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (1'b1),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Subtraction wraps modulo SAMPLES through the IDX_W-bit result width
  always_comb begin
    sel_idx  = req_idx[int'(grant_id)*IDX_W +: IDX_W];
    next_idx = req_sin[grant_id] ? sel_idx - QUARTER : sel_idx;
  end

  // Tag stage 0 lines up with lut_idx; stage PIPE_D-1 lines up with lut_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_idx <= '0;
      tag_v   <= '0;
      tag_id  <= '0;
    end else begin
      if (grant_any) lut_idx <= next_idx;
      tag_v  <= {tag_v[PIPE_D-2:0], grant_any};
      tag_id <= {tag_id[PIPE_D-2:0], grant_id};
    end
  end

  // NOTE: a default '<=' followed by a conditional '<=' to one bit is safe:
  // the last non-blocking assignment in the block wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v[PIPE_D-1]) begin
        rsp_valid[tag_id[PIPE_D-1]] <= 1'b1;
        rsp_data[int'(tag_id[PIPE_D-1])*DATA_W +: DATA_W] <= lut_data;
      end
    end
  end

endmodule

// File: tb/tb_cosine_lut_arbiter.sv
// Self-checking bench for cosine_lut_arbiter with a 1-cycle cosine LUT model
// and a transaction-level scoreboard of grants and responses.
module tb_cosine_lut_arbiter;
  import modem_pkg::*;

  localparam int NR   = 4;
  localparam int SMP  = 512;
  localparam int DW   = 24;
  localparam int IW   = 9;
  localparam int LAT  = 3;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_sin;
  logic [NR*IW-1:0]  req_idx;
  logic [NR-1:0]     req_ready;
  logic [IW-1:0]     lut_idx;
  logic [DW-1:0]     lut_data;
  logic [NR-1:0]     rsp_valid;
  logic [NR*DW-1:0]  rsp_data;

  cosine_lut_arbiter #(
    .NUM_REQ(NR), .SAMPLES(SMP), .DATA_W(DW), .LUT_LATENCY(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sin   (req_sin),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .lut_idx   (lut_idx),
    .lut_data  (lut_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cosine LUT stand-in: distinct entries, one cycle read latency
  logic [DW-1:0] lut_mem [SMP];
  always @(posedge clk) lut_data <= lut_mem[lut_idx];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } pend_t;

  int            checks;
  int            errors;
  int            cyc;
  int            rr_last;
  int            exp_lut;
  int            rsp_seen [NR];
  logic [DW-1:0] exp_data [NR];
  pend_t         pend [$];

  function automatic int lut_addr(input int idx, input logic sin);
    return sin ? (idx + SMP - SMP/4) % SMP : idx;
  endfunction

  function automatic logic [NR*DW-1:0] exp_packed();
    logic [NR*DW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = exp_data[r];
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    rr_last = NR - 1;
    exp_lut = 0;
    for (int r = 0; r < NR; r++) exp_data[r] = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, predict the grant
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] s,
                      input logic [NR*IW-1:0] idx, output logic [NR-1:0] g);
    logic [NR-1:0] exp_rv;
    pend_t         e;
    int            win;
    int            a;
    @(negedge clk);
    req_valid = v;
    req_sin   = s;
    req_idx   = idx;
    #1;
    cyc++;
    checks++;
    if (lut_idx !== IW'(exp_lut)) begin
      errors++;
      $display("FAIL lut_idx cyc=%0d got=%0d exp=%0d", cyc, lut_idx, exp_lut);
    end
    exp_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      exp_rv[e.id] = 1'b1;
      exp_data[e.id] = e.data;
    end
    checks++;
    if (rsp_valid !== exp_rv) begin
      errors++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
    end
    checks++;
    if (rsp_data !== exp_packed()) begin
      errors++;
      $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_packed());
    end
    for (int r = 0; r < NR; r++) if (rsp_valid[r] === 1'b1) rsp_seen[r]++;
    g   = '0;
    win = -1;
    for (int k = 1; k <= NR; k++) begin
      if (win < 0 && v[(rr_last + k) % NR]) win = (rr_last + k) % NR;
    end
    if (win >= 0) g[win] = 1'b1;
    checks++;
    if (req_ready !== g) begin
      errors++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, g);
    end
    if (win >= 0) begin
      rr_last = win;
      a = int'(idx[win*IW +: IW]);
      exp_lut = lut_addr(a, s[win]);
      pend.push_back('{due: cyc + LAT, id: win, data: lut_mem[exp_lut]});
    end
  endtask

  task automatic idle(input int n);
    logic [NR-1:0] g;
    for (int i = 0; i < n; i++) step('0, '0, '0, g);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_sin = '0;
    req_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++;
    if (lut_idx !== '0) begin errors++; $display("FAIL reset_lut_idx got=%0d exp=0", lut_idx); end
    checks++;
    if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NR*IW-1:0] idx;
    logic [NR-1:0]    s;
    logic [NR-1:0]    g;
    logic [NR-1:0]    want;
    idx = NR*IW'($urandom);
    s   = NR'($urandom);
    for (int k = 0; k < 8; k++) begin
      step('1, s, idx, g);
      want = NR'(1) << (k % NR);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL rr_order k=%0d got=%b exp=%b", k, req_ready, want);
      end
    end
    idle(LAT + 1);
  endtask

  task automatic test_single_cos();
    logic [NR-1:0] g;
    step(4'b0001, '0, '0, g);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL cos_ready got=%b exp=0001", req_ready); end
    idle(1);
    checks++;
    if (lut_idx !== '0) begin errors++; $display("FAIL cos_lut_idx got=%0d exp=0", lut_idx); end
    idle(2);
    checks++;
    if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL cos_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++;
    if (rsp_data[DW-1:0] !== lut_mem[0]) begin
      errors++;
      $display("FAIL cos_rsp_data got=%h exp=%h", rsp_data[DW-1:0], lut_mem[0]);
    end
    idle(1);
  endtask

  task automatic test_sin();
    int            in_idx  [3] = '{0, 200, 128};
    int            out_idx [3] = '{384, 72, 0};
    logic [NR-1:0] g;
    for (int t = 0; t < 3; t++) begin
      step(4'b0100, 4'b0100, (NR*IW)'(in_idx[t]) << (2*IW), g);
      idle(1);
      checks++;
      if (lut_idx !== IW'(out_idx[t])) begin
        errors++;
        $display("FAIL sin_lut_idx in=%0d got=%0d exp=%0d", in_idx[t], lut_idx, out_idx[t]);
      end
      idle(2);
      checks++;
      if (rsp_data[2*DW +: DW] !== lut_mem[out_idx[t]]) begin
        errors++;
        $display("FAIL sin_rsp_data in=%0d got=%h exp=%h", in_idx[t], rsp_data[2*DW +: DW], lut_mem[out_idx[t]]);
      end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] g;
    int            grants;
    int            rsp0;
    grants = 0;
    rsp0   = rsp_seen[1];
    for (int i = 0; i < SMP; i++) begin
      step(4'b0010, '0, (NR*IW)'(i) << IW, g);
      if (req_ready === 4'b0010) grants++;
    end
    idle(LAT + 1);
    checks++;
    if (grants != SMP) begin errors++; $display("FAIL b2b_grants got=%0d exp=%0d", grants, SMP); end
    checks++;
    if (rsp_seen[1] - rsp0 != SMP) begin
      errors++;
      $display("FAIL b2b_responses got=%0d exp=%0d", rsp_seen[1] - rsp0, SMP);
    end
  endtask

  task automatic test_mid_reset();
    logic [NR-1:0] g;
    step(4'b0001, '0, (NR*IW)'(17), g);
    step(4'b0010, 4'b0010, (NR*IW)'(33) << IW, g);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
    checks++;
    if (lut_idx !== '0) begin errors++; $display("FAIL mid_rst_lut_idx got=%0d exp=0", lut_idx); end
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL mid_rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    model_reset();
    idle(LAT + 2);
    step('1, '0, '0, g);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_first_grant got=%b exp=0001", req_ready); end
    idle(LAT + 1);
  endtask

  task automatic test_random();
    logic [NR-1:0]    v;
    logic [NR-1:0]    s;
    logic [NR*IW-1:0] idx;
    logic [NR-1:0]    g;
    int               waitc [NR];
    v   = '0;
    s   = '0;
    idx = '0;
    for (int r = 0; r < NR; r++) waitc[r] = 0;
    for (int n = 0; n < 10000; n++) begin
      step(v, s, idx, g);
      checks++;
      if (!$onehot0(req_ready)) begin errors++; $display("FAIL rand_onehot cyc=%0d got=%b", cyc, req_ready); end
      for (int r = 0; r < NR; r++) begin
        if (v[r] && g[r]) begin
          checks++;
          if (waitc[r] > NR - 1) begin
            errors++;
            $display("FAIL rand_starve req=%0d waited=%0d max=%0d", r, waitc[r], NR - 1);
          end
          waitc[r] = 0;
          v[r] = ($urandom_range(3) != 0);
          s[r] = 1'($urandom);
          idx[r*IW +: IW] = IW'($urandom);
        end else if (v[r]) begin
          waitc[r]++;
        end else if ($urandom_range(1) == 1) begin
          v[r] = 1'b1;
          s[r] = 1'($urandom);
          idx[r*IW +: IW] = IW'($urandom);
        end
      end
    end
    idle(LAT + 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int r = 0; r < NR; r++) rsp_seen[r] = 0;
    for (int i = 0; i < SMP; i++) lut_mem[i] = DW'(i * 40503 + 12345);
    test_reset();
    test_round_robin();
    test_single_cos();
    test_sin();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
